// File: rtl/mem_wb_skid_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv32i_types : shared types for the MEM/WB skid stage (states, load funct3, |
// |               RVFI-style monitor record, load read-mask helper)            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package rv32i_types;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_t;

    // Destination register field inside the opaque payload's packed control word.
    localparam int RD_LSB = 7;
    localparam int RD_W   = 5;

    typedef struct packed {
        logic        commit;
        logic [4:0]  rd_addr;
        logic [3:0]  mem_rmask;
        logic [31:0] pc_rdata;
        logic [31:0] insn;
    } monitor_t;

    function automatic logic [3:0] load_rmask(
        input logic [2:0] funct3,
        input logic [1:0] addr_lo,
        input logic       is_load
    );
        logic [3:0] mask;
        mask = 4'b1111;
        case (load_funct3_t'(funct3))
            F3_LB, F3_LBU: mask = 4'b0001 << addr_lo;
            F3_LH, F3_LHU: mask = 4'b0011 << {addr_lo[1], 1'b0};
            default:       mask = 4'b1111;
        endcase
        if (!is_load) begin
            mask = 4'b0000;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_skid_stage_entry.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | skid_entry_reg : one valid-tagged entry register of the MEM/WB skid buffer |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module skid_entry_reg #(
    parameter int PAYLOAD_W = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 load,
    input  logic                 drop,
    input  logic [PAYLOAD_W-1:0] d,
    output logic [PAYLOAD_W-1:0] q,
    output logic                 valid
);

    // Data is zeroed only by reset; flush just invalidates the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_skid_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_wb_skid_stage : MEM/WB pipeline register with a 2-entry skid buffer,   |
// |   registered in_ready, flush, and per-entry load read masks.               |
// |   Optional RVFI monitor passthrough: define MEM_WB_SKID_MONITOR_EN.        |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module mem_wb_skid_stage
    import rv32i_types::*;
#(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [XLEN-1:0]      in_addr,
    input  logic                 in_is_load,
    input  logic [2:0]           in_funct3,
    input  logic                 in_commit,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [XLEN-1:0]      out_addr,
    output logic [3:0]           out_rmask,
    output logic                 out_bubble
`ifdef MEM_WB_SKID_MONITOR_EN
    ,
    input  monitor_t             in_monitor,
    output monitor_t             out_monitor
`endif
);

    localparam int BASE_W = PAYLOAD_W + XLEN + 4 + 1;
`ifdef MEM_WB_SKID_MONITOR_EN
    localparam int ENTRY_W = BASE_W + $bits(monitor_t);
`else
    localparam int ENTRY_W = BASE_W;
`endif

    skid_state_t state;
    skid_state_t state_next;

    logic               ready_q;
    logic               accept;
    logic               pop;
    logic               head_load;
    logic               head_from_skid;
    logic               head_drop;
    logic               skid_load;
    logic               skid_drop;
    logic               head_valid;
    logic               skid_valid;
    logic [3:0]         in_rmask;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_d;
    logic [ENTRY_W-1:0] head_q;
    logic [ENTRY_W-1:0] skid_q;

    logic [PAYLOAD_W-1:0] head_payload;
    logic [XLEN-1:0]      head_addr;
    logic [3:0]           head_rmask;
    logic                 head_commit;

    assign accept   = in_valid & in_ready;
    assign pop      = head_valid & out_ready;
    assign in_rmask = load_rmask(in_funct3, in_addr[1:0], in_is_load);

`ifdef MEM_WB_SKID_MONITOR_EN
    monitor_t in_mon_upd;
    monitor_t head_mon;

    always_comb begin
        in_mon_upd           = in_monitor;
        in_mon_upd.rd_addr   = in_payload[RD_LSB +: RD_W];
        in_mon_upd.mem_rmask = in_rmask;
    end

    assign in_entry = {in_mon_upd, in_payload, in_addr, in_rmask, in_commit};
    assign head_mon = head_q[ENTRY_W-1:BASE_W];

    always_comb begin
        out_monitor        = head_mon;
        out_monitor.commit = head_mon.commit & head_valid;
    end
`else
    assign in_entry = {in_payload, in_addr, in_rmask, in_commit};
`endif

    assign {head_payload, head_addr, head_rmask, head_commit} = head_q[BASE_W-1:0];

    // ------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        head_drop      = 1'b0;
        skid_load      = 1'b0;
        skid_drop      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_load  = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        skid_load  = 1'b1;
                        state_next = TWO;
                    end else if (pop) begin
                        head_drop  = 1'b1;
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_drop      = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Ready is a flop; masking with rst only holds it low while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_next != TWO);
        end
    end

    assign in_ready = ready_q & ~rst;

    assign head_d = head_from_skid ? skid_q : in_entry;

    skid_entry_reg #(
        .PAYLOAD_W (ENTRY_W)
    ) u_head (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (head_load),
        .drop  (head_drop),
        .d     (head_d),
        .q     (head_q),
        .valid (head_valid)
    );

    skid_entry_reg #(
        .PAYLOAD_W (ENTRY_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (skid_load),
        .drop  (skid_drop),
        .d     (in_entry),
        .q     (skid_q),
        .valid (skid_valid)
    );

    assign out_valid   = head_valid;
    assign out_payload = head_payload;
    assign out_addr    = head_addr;
    assign out_rmask   = head_rmask & {4{head_valid}};
    assign out_bubble  = head_valid & ~head_commit;

    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid_stage.sv
`default_nettype none
// Randomised and directed bench for mem_wb_skid_stage against a queue-based model.
module tb_mem_wb_skid_stage;

    localparam int XLEN = 32;
    localparam int PW   = 96;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   in_payload;
    logic [XLEN-1:0] in_addr;
    logic            in_is_load;
    logic [2:0]      in_funct3;
    logic            in_commit;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   out_payload;
    logic [XLEN-1:0] out_addr;
    logic [3:0]      out_rmask;
    logic            out_bubble;
`ifdef MEM_WB_SKID_MONITOR_EN
    rv32i_types::monitor_t in_monitor = '0;
    rv32i_types::monitor_t out_monitor;
`endif

    always #5 clk = ~clk;

    mem_wb_skid_stage #(.XLEN(XLEN), .PAYLOAD_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_addr     (in_addr),
        .in_is_load  (in_is_load),
        .in_funct3   (in_funct3),
        .in_commit   (in_commit),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .out_addr    (out_addr),
        .out_rmask   (out_rmask),
        .out_bubble  (out_bubble)
`ifdef MEM_WB_SKID_MONITOR_EN
        ,
        .in_monitor  (in_monitor),
        .out_monitor (out_monitor)
`endif
    );

    typedef struct {
        logic [PW-1:0]   p;
        logic [XLEN-1:0] a;
        logic [3:0]      m;
        logic            c;
    } ent_t;

    ent_t mq[$];
    int   tests = 0;
    int   fails = 0;

    // Mask = (2^bytes - 1) placed at the naturally aligned byte offset.
    function automatic logic [3:0] ref_mask(logic is_load, logic [2:0] f3, logic [XLEN-1:0] addr);
        int n;
        int base;
        if (!is_load) return 4'b0000;
        case (f3)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            default:    n = 4;
        endcase
        base = (int'(addr % 4) / n) * n;
        return 4'(((1 << n) - 1) << base);
    endfunction

    function automatic logic exp_ready();
        return !rst && (mq.size() < 2);
    endfunction

    // One clock: inputs already applied; model updated with pre-edge values; returns at negedge.
    task automatic tick();
        bit   acc;
        bit   pp;
        bit   clr;
        ent_t e;
        acc = in_valid && exp_ready();
        pp  = (mq.size() > 0) && out_ready && !rst;
        clr = rst || flush;
        e.p = in_payload;
        e.a = in_addr;
        e.m = ref_mask(in_is_load, in_funct3, in_addr);
        e.c = in_commit;
        @(posedge clk);
        if (clr) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic set_in(logic v, logic [PW-1:0] p, logic [XLEN-1:0] a, logic ld, logic [2:0] f3, logic c);
        in_valid   = v;
        in_payload = p;
        in_addr    = a;
        in_is_load = ld;
        in_funct3  = f3;
        in_commit  = c;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, '0, '0, 1'b0, 3'd0, 1'b0);
        repeat (3) tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        tests++; if (out_payload !== '0 || out_addr !== '0) begin fails++; $display("FAIL reset_data got=%h/%h exp=0", out_payload, out_addr); end
        tests++; if (out_rmask !== 4'b0 || out_bubble !== 1'b0) begin fails++; $display("FAIL reset_mask got=%b/%b exp=0", out_rmask, out_bubble); end
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, PW'(i + 1), 32'h100 + 32'(4 * i), 1'b1, 3'd2, 1'b1);
            tick();
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid); end
            tests++; if (out_payload !== PW'(i + 1) || out_addr !== 32'h100 + 32'(4 * i)) begin
                fails++; $display("FAIL b2b_data[%0d] got=%h/%h exp=%0d/%h", i, out_payload, out_addr, i + 1, 32'h100 + 32'(4 * i)); end
            tests++; if (out_rmask !== 4'b1111) begin fails++; $display("FAIL b2b_rmask[%0d] got=%b exp=1111", i, out_rmask); end
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] exp_seq [3];
        logic [PW-1:0] got[$];
        bit            acc;
        exp_seq[0] = PW'(96'hA);
        exp_seq[1] = PW'(96'hB);
        exp_seq[2] = PW'(96'hC);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, exp_seq[i], 32'h200 + 32'(4 * i), 1'b1, 3'd2, 1'b1);
            tests++; if (in_ready !== (i < 2)) begin fails++; $display("FAIL bp_ready[%0d] got=%b exp=%b", i, in_ready, i < 2); end
            tick();
        end
        tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (out_valid && out_ready) got.push_back(out_payload);
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        tests++; if (got.size() !== 3) begin fails++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== exp_seq[i]) begin
                fails++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : '0, exp_seq[i]);
            end
        end
    endtask

    task automatic test_rmask();
        logic            ld  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]      f3  [6] = '{3'd0, 3'd1, 3'd5, 3'd2, 3'd4, 3'd3};
        logic [XLEN-1:0] ad  [6] = '{32'h1003, 32'h2002, 32'h3000, 32'h4001, 32'h5001, 32'h6002};
        logic [3:0]      exm [6] = '{4'b1000, 4'b1100, 4'b0011, 4'b0000, 4'b0010, 4'b1111};
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b0;
            set_in(1'b1, PW'(i), ad[i], ld[i], f3[i], 1'b1);
            tick();
            in_valid = 1'b0;
            tests++; if (out_rmask !== exm[i]) begin fails++; $display("FAIL rmask[%0d] got=%b exp=%b", i, out_rmask, exm[i]); end
            out_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, PW'(96'hE0 + i), 32'h300, 1'b1, 3'd2, 1'b1);
            tick();
        end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_two_ready got=%b exp=0", in_ready); end
        flush = 1'b1;
        set_in(1'b1, PW'(96'hF1), 32'h304, 1'b1, 3'd2, 1'b1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_two got valid=%b ready=%b exp 0/1", out_valid, in_ready); end
        // Flush from ONE with an entry that would otherwise have been accepted.
        set_in(1'b1, PW'(96'hE5), 32'h308, 1'b1, 3'd2, 1'b1);
        tick();
        flush = 1'b1;
        set_in(1'b1, PW'(96'hF2), 32'h30C, 1'b1, 3'd2, 1'b1);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_one_leak[%0d] got=%b payload=%h exp=0", k, out_valid, out_payload); end
            tick();
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        set_in(1'b1, PW'(96'hBB), 32'h402, 1'b1, 3'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        tests++; if (out_bubble !== 1'b1) begin fails++; $display("FAIL bubble_set got=%b exp=1", out_bubble); end
        tests++; if (out_rmask !== 4'b1100) begin fails++; $display("FAIL bubble_rmask got=%b exp=1100", out_rmask); end
        out_ready = 1'b1;
        tick();
        tests++; if (out_bubble !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL bubble_pop got bubble=%b valid=%b exp 0/0", out_bubble, out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_in(1'b1, PW'(96'hD1), 32'h500, 1'b1, 3'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rmid_pre got=%b exp=1", out_valid); end
        rst = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL rmid_during got valid=%b ready=%b exp 0/0", out_valid, in_ready); end
        tests++; if (out_payload !== '0 || out_addr !== '0 || out_rmask !== 4'b0 || out_bubble !== 1'b0) begin
            fails++; $display("FAIL rmid_zero got=%h/%h/%b/%b exp=0", out_payload, out_addr, out_rmask, out_bubble); end
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got=%b exp=1", in_ready); end
        set_in(1'b1, PW'(96'hD2), 32'h504, 1'b1, 3'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_payload !== PW'(96'hD2) || out_rmask !== 4'b0001) begin
            fails++; $display("FAIL rmid_accept got valid=%b payload=%h rmask=%b exp 1/d2/0001", out_valid, out_payload, out_rmask); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            set_in($urandom_range(0, 3) != 0, {$urandom(), $urandom(), $urandom()}, $urandom(),
                   1'($urandom()), 3'($urandom()), $urandom_range(0, 4) != 0);
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 24) == 0;
            tests++;
            if (out_valid !== (mq.size() > 0) || in_ready !== exp_ready()) begin
                fails++; $display("FAIL rnd_ctrl[%0d] got valid=%b ready=%b exp %b/%b", k, out_valid, in_ready, mq.size() > 0, exp_ready());
            end
            tests++;
            if (mq.size() > 0) begin
                if (out_payload !== mq[0].p || out_addr !== mq[0].a || out_rmask !== mq[0].m || out_bubble !== !mq[0].c) begin
                    fails++; $display("FAIL rnd_head[%0d] got %h/%h/%b/%b exp %h/%h/%b/%b", k, out_payload, out_addr,
                                      out_rmask, out_bubble, mq[0].p, mq[0].a, mq[0].m, !mq[0].c);
                end
            end else if (out_rmask !== 4'b0 || out_bubble !== 1'b0) begin
                fails++; $display("FAIL rnd_idle[%0d] got rmask=%b bubble=%b exp 0/0", k, out_rmask, out_bubble);
            end
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_rmask();
        test_flush();
        test_bubble();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised successor of the MEM/WB pipeline register.
- Carries an opaque control/data payload plus a memory address from MEM to WB, with a valid/ready handshake instead of a global load enable.
- A 2-entry skid buffer lets `in_ready` be fully registered, so backpressure never forms a combinational path; a synchronous flush clears both entries.
- Generates per-entry RVFI-style load read masks and a commit/bubble indication for the monitor.

Parameters:
- XLEN, 32, width of the address and data path.
- PAYLOAD_W, 96, width of the opaque payload (packed control word, ALU result, immediates).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  MEM stage presents an entry
- in_ready  output  1  stage can accept; registered
- in_payload  input  PAYLOAD_W  opaque payload
- in_addr  input  XLEN  memory address (ALU result)
- in_is_load  input  1  entry is a load (opcode == op_load)
- in_funct3  input  3  load width/sign
- in_commit  input  1  entry is a real instruction (0 = bubble)
- flush  input  1  discard all held entries
- out_valid  output  1  head entry valid
- out_ready  input  1  WB consumes head
- out_payload  output  PAYLOAD_W  head payload
- out_addr  output  XLEN  head address
- out_rmask  output  4  head load byte mask
- out_bubble  output  1  out_valid & ~head commit

Behaviour:
- Storage: main register (head) and skid register, each holding {payload, addr, rmask, commit, valid}.
- States:
  - EMPTY: no valid entries.
  - ONE: head valid, skid empty.
  - TWO: head and skid valid.
- Handshake:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready = (next state != TWO), registered. It is therefore 1 in EMPTY and ONE and 0 in TWO.
- Transitions, non-flush:
  - EMPTY + accept -> ONE. Head is loaded; out_valid rises the next cycle (latency 1).
  - ONE + accept + pop -> ONE. Head is replaced by the new entry.
  - ONE + accept, no pop -> TWO. The new entry goes to skid.
  - ONE + pop, no accept -> EMPTY.
  - TWO + pop -> ONE. Skid moves to head. No accept is possible in TWO.
  - All other combinations hold state and contents.
- Ordering: strict FIFO. Entries are never dropped or duplicated except on flush.
- Flush:
  - Takes priority over accept and pop in the same cycle.
  - Next state is EMPTY, both valids are cleared, and in_ready = 1 the next cycle.
  - An entry offered in the flush cycle is discarded.
  - Payload registers need not clear.
- rmask, computed at accept from in_funct3 and in_addr[1:0], and stored with the entry:
  - lw: 1111.
  - lh/lhu: 0011 << {addr[1],1'b0}.
  - lb/lbu: 0001 << addr[1:0].
  - Other funct3 with in_is_load=1: 1111.
  - in_is_load=0: 0000.
- out_rmask and out_bubble are 0 whenever out_valid = 0.
- Reset:
  - State is EMPTY.
  - out_valid=0, in_ready=0 during reset and 1 in the first cycle after it.
  - out_payload, out_addr, out_rmask and out_bubble are all 0.
  - Reset mid-operation discards all entries identically to flush.
- Outputs are taken directly from head registers (no combinational input-to-output path).

Optional Feature:
- Macro: MEM_WB_SKID_MONITOR_EN.
- Defined:
  - Adds ports `in_monitor` (input, monitor_t) and `out_monitor` (output, monitor_t).
  - monitor_t is carried alongside each entry through the skid buffer.
  - At accept, the stage overwrites `rd_addr` with in_payload's rd field and `mem_rmask` with the computed rmask.
  - `commit` is forced to 0 on output when out_valid=0.
- Undefined: no monitor ports or storage; the RVFI fields are not available.

Decomposition:
- rv32i_types package: skid_state_t enum {EMPTY, ONE, TWO}, load_funct3_t reuse, and an rmask function `load_rmask(funct3, addr_lo, is_load)`.
- One sub-module, `skid_entry_reg`: a single valid-tagged entry register parametrised by PAYLOAD_W, instantiated twice (head, skid).

Test Plan:
- Reset, then in_valid=1, out_ready=1, 4 back-to-back entries (addr 0x100..0x10C, lw) -> out_valid the next cycle, one entry per cycle in order, rmask=1111, in_ready stays 1.
- Hold out_ready=0 while offering 3 entries A,B,C -> A and B accepted, in_ready=0 from cycle 2, C held. Release out_ready -> A, B, C delivered in order with no loss.
- lb at addr 0x...3 -> rmask 1000. lh at 0x...2 -> 1100. lhu at 0x...0 -> 0011. Store (in_is_load=0) -> 0000.
- In state TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed entry never appears.
- Entry with in_commit=0 -> out_bubble=1 while it is head. out_rmask still as computed. Pop clears it.
- Assert rst for 1 cycle while in ONE with out_ready=0 -> out_valid=0, in_ready=0 during reset, then 1. Outputs are zero; subsequent accept behaves as from EMPTY.
